seven_seg_scan_controller: RTL and testbench

Time-multiplexed scan controller for a NUM_DIGITS common-enable seven-segment display. All digits share one 4-bit to 7-segment decoder. The block holds a display value in double-buffered registers and steps through the digits with a guard blanking interval between them. It sits between game logic, which writes values through a load strobe, and the board's segment and digit-enable pins.

---
 rtl/seven_seg_scan_controller_pkg.sv | 27 ++
 rtl/seven_seg_scan_controller_decoder.sv | 12 +
 rtl/seven_seg_scan_controller_scan_timer.sv | 31 +++
 rtl/seven_seg_scan_controller.sv | 144 ++++++++++++++
 tb/tb_seven_seg_scan_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scan_controller_pkg.sv
// Shared display definitions: scan state encoding, blank segment value and hex segment table.
// Bit order of every segment word is g..a (bit6..bit0), active-high.
package seven_seg_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Entry [n] is the glyph for hex digit n; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Counter width able to hold 0..max(a,b)-1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/seven_seg_scan_controller_decoder.sv
// Combinational 4-bit hex to seven-segment decoder (g..a, active-high).
// Zero latency, no flow control.
module hex_seven_seg_decoder
    import seven_seg_scan_controller_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scan_controller_scan_timer.sv
// Cycle counter with synchronous clear/load and a terminal-count compare.
// tc is combinational from the registered count; no flow control.
module scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed seven-segment scan with double-buffered value, guard blanking and leading-zero suppression.
// Outputs registered, one cycle behind the scan state; loads always accepted, no backpressure.
module seven_seg_scan_controller
    import seven_seg_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 50000,
    parameter int BLANK_CLKS     = 500
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_ENABLE,
    input  logic [4*NUM_DIGITS-1:0] i_VALUE,
    input  logic                    i_LOAD,
    input  logic                    i_BLANK_LZ,
    output logic                    o_LOAD_ACK,
    output logic [6:0]              o_SEVEN_SEG,
    output logic [NUM_DIGITS-1:0]   o_DIGIT_EN,
    output logic                    o_FRAME_DONE
);

    localparam int CNT_W = cnt_width(CLKS_PER_DIGIT, BLANK_CLKS);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CLKS > 0) ? BLANK_CLKS - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_t      SLOT_ENTRY = (BLANK_CLKS == 0) ? ST_DRIVE : ST_BLANK;

    scan_state_t                 state;
    logic [IDX_W-1:0]            idx;
    logic [NUM_DIGITS-1:0][3:0]  shadow;
    logic [NUM_DIGITS-1:0][3:0]  active;
    logic                        pending;

    logic                        tc;
    logic                        timer_clear;
    logic [CNT_W-1:0]            terminal;
    logic [3:0]                  nibble;
    logic [6:0]                  seg;
    logic [NUM_DIGITS-1:0]       nz_above;
    logic                        shown;
    logic [NUM_DIGITS-1:0]       en_mask;

    // Any slot end or leaving the scan restarts the count from zero.
    assign timer_clear = (state == ST_IDLE) || !i_ENABLE || tc;
    assign terminal    = (state == ST_BLANK) ? BLANK_LAST : DRIVE_LAST;

    scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (i_CLK),
        .rst        (i_RST),
        .clear      (timer_clear),
        .load       (1'b0),
        .load_value ({CNT_W{1'b0}}),
        .terminal   (terminal),
        .tc         (tc)
    );

    assign nibble = active[idx];

    hex_seven_seg_decoder u_dec (
        .nibble (nibble),
        .seg    (seg)
    );

    // nz_above[k] is set when any of nibbles k..NUM_DIGITS-1 is non-zero.
    always_comb begin
        nz_above = '0;
        nz_above[NUM_DIGITS-1] = |active[NUM_DIGITS-1];
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            nz_above[k] = nz_above[k+1] | (|active[k]);
        end
    end

    assign shown   = (idx == '0) || !i_BLANK_LZ || nz_above[idx];
    assign en_mask = NUM_DIGITS'(1) << idx;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state        <= ST_IDLE;
            idx          <= '0;
            shadow       <= '0;
            active       <= '0;
            pending      <= 1'b0;
            o_LOAD_ACK   <= 1'b0;
            o_SEVEN_SEG  <= SEG_OFF;
            o_DIGIT_EN   <= '0;
            o_FRAME_DONE <= 1'b0;
        end else begin
            o_LOAD_ACK   <= i_LOAD;
            o_FRAME_DONE <= 1'b0;
            o_SEVEN_SEG  <= SEG_OFF;
            o_DIGIT_EN   <= '0;

            if (i_LOAD) begin
                shadow  <= i_VALUE;
                pending <= 1'b1;
            end

            if (!i_ENABLE) begin
                state <= ST_IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= SLOT_ENTRY;
                        idx   <= '0;
                        if (pending) begin
                            active <= shadow;
                            if (!i_LOAD) pending <= 1'b0;
                        end
                    end
                    ST_BLANK: begin
                        if (tc) state <= ST_DRIVE;
                    end
                    ST_DRIVE: begin
                        if (shown) begin
                            o_DIGIT_EN  <= en_mask;
                            o_SEVEN_SEG <= seg;
                        end
                        if (tc) begin
                            state <= SLOT_ENTRY;
                            if (idx == LAST_IDX) begin
                                idx          <= '0;
                                o_FRAME_DONE <= 1'b1;
                                // A load on this edge keeps its value pending for the next frame.
                                if (pending) begin
                                    active <= shadow;
                                    if (!i_LOAD) pending <= 1'b0;
                                end
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Directed bench for the scan controller with 4 digits, 4 drive cycles and 2 guard cycles.
// Frames are captured slot by slot and compared against hand-written glyph constants.
module tb_seven_seg_scan_controller;

    logic        i_CLK = 1'b0;
    logic        i_RST = 1'b1;
    logic        i_ENABLE = 1'b0;
    logic [15:0] i_VALUE = 16'h0000;
    logic        i_LOAD = 1'b0;
    logic        i_BLANK_LZ = 1'b0;
    logic        o_LOAD_ACK;
    logic [6:0]  o_SEVEN_SEG;
    logic [3:0]  o_DIGIT_EN;
    logic        o_FRAME_DONE;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_cap [4];
    int         on_cap  [4];
    int         fd_cnt;
    int         fd_at;
    int         pos_err;

    seven_seg_scan_controller #(
        .NUM_DIGITS     (4),
        .CLKS_PER_DIGIT (4),
        .BLANK_CLKS     (2)
    ) dut (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_ENABLE     (i_ENABLE),
        .i_VALUE      (i_VALUE),
        .i_LOAD       (i_LOAD),
        .i_BLANK_LZ   (i_BLANK_LZ),
        .o_LOAD_ACK   (o_LOAD_ACK),
        .o_SEVEN_SEG  (o_SEVEN_SEG),
        .o_DIGIT_EN   (o_DIGIT_EN),
        .o_FRAME_DONE (o_FRAME_DONE)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic load_now(input logic [15:0] v);
        i_LOAD  = 1'b1;
        i_VALUE = v;
        @(negedge i_CLK);
        i_LOAD  = 1'b0;
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (!o_FRAME_DONE && n < 200) begin
            @(negedge i_CLK);
            n++;
        end
        if (!o_FRAME_DONE) check_eq("wait_frame_done_timeout", 32'd0, 32'd1);
    endtask

    // Samples 24 cycles: slot s%6 of digit s/6 is dark for 2 cycles then lit for 4.
    // la/lb (>=0) inject single-cycle loads right after that sample.
    task automatic grab(input int la, input logic [15:0] va, input int lb, input logic [15:0] vb);
        logic [3:0] exp_en;
        int d;
        int slot;
        for (int k = 0; k < 4; k++) begin
            seg_cap[k] = 7'h00;
            on_cap[k]  = 0;
        end
        fd_cnt  = 0;
        fd_at   = -1;
        pos_err = 0;
        for (int s = 0; s < 24; s++) begin
            @(negedge i_CLK);
            d      = s / 6;
            slot   = s % 6;
            exp_en = 4'(1 << d);
            if (o_FRAME_DONE) begin
                fd_cnt++;
                fd_at = s;
            end
            if (o_DIGIT_EN != 4'b0000) begin
                if (slot < 2 || o_DIGIT_EN != exp_en) pos_err++;
                else begin
                    on_cap[d]++;
                    seg_cap[d] = o_SEVEN_SEG;
                end
            end else if (o_SEVEN_SEG != 7'h00) begin
                pos_err++;
            end
            i_LOAD = 1'b0;
            if (s == la) begin
                i_LOAD  = 1'b1;
                i_VALUE = va;
            end
            if (s == lb) begin
                i_LOAD  = 1'b1;
                i_VALUE = vb;
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("%s_seg%0d", tag, k), 32'(seg_cap[k]), 32'(exp_seg[k]));
            check_eq($sformatf("%s_on%0d", tag, k), 32'(on_cap[k]), (exp_seg[k] != 7'h00) ? 32'd4 : 32'd0);
        end
        check_eq({tag, "_fd_count"}, 32'(fd_cnt), 32'd1);
        check_eq({tag, "_fd_pos"}, 32'(fd_at), 32'd23);
        check_eq({tag, "_slot_err"}, 32'(pos_err), 32'd0);
    endtask

    initial begin
        int fd_seen;

        // Reset state
        repeat (2) @(negedge i_CLK);
        check_eq("rst_seg", 32'(o_SEVEN_SEG), 32'h0);
        check_eq("rst_en", 32'(o_DIGIT_EN), 32'h0);
        check_eq("rst_fd", 32'(o_FRAME_DONE), 32'h0);
        check_eq("rst_ack", 32'(o_LOAD_ACK), 32'h0);
        i_RST = 1'b0;

        // 1: load while idle, then first frame and steady period
        @(negedge i_CLK);
        load_now(16'h1234);
        check_eq("t1_ack_hi", 32'(o_LOAD_ACK), 32'h1);
        @(negedge i_CLK);
        check_eq("t1_ack_lo", 32'(o_LOAD_ACK), 32'h0);
        i_ENABLE = 1'b1;
        @(negedge i_CLK);
        check_eq("t1_idle_dark", 32'(o_DIGIT_EN), 32'h0);
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t1_first", 7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110);
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t1_second", 7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110);

        // 2: leading-zero suppression
        i_BLANK_LZ = 1'b1;
        load_now(16'h0070);
        wait_fd();
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t2_0070", 7'b0111111, 7'b0000111, 7'b0000000, 7'b0000000);
        load_now(16'h0000);
        wait_fd();
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t2_0000", 7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000);

        // 3: mid-frame load does not tear
        i_BLANK_LZ = 1'b0;
        load_now(16'h1234);
        wait_fd();
        grab(15, 16'hABCD, -1, 16'h0);
        check_frame("t3_old", 7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110);
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t3_new", 7'b1011110, 7'b0111001, 7'b1111100, 7'b1110111);

        // 4: load on the transfer cycle stays pending one frame
        grab(3, 16'h1357, 22, 16'h5678);
        check_frame("t4_cur", 7'b1011110, 7'b0111001, 7'b1111100, 7'b1110111);
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t4_preload", 7'b0000111, 7'b1101101, 7'b1001111, 7'b0000110);
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t4_latest", 7'b1111111, 7'b0000111, 7'b1111101, 7'b1101101);

        // 5: disable mid-DRIVE of digit 1, load while dark, re-enable
        repeat (9) @(negedge i_CLK);
        check_eq("t5_pre_en", 32'(o_DIGIT_EN), 32'h2);
        i_ENABLE = 1'b0;
        @(negedge i_CLK);
        check_eq("t5_off_en", 32'(o_DIGIT_EN), 32'h0);
        check_eq("t5_off_seg", 32'(o_SEVEN_SEG), 32'h0);
        fd_seen = (o_FRAME_DONE) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_CLK);
            if (o_FRAME_DONE) fd_seen++;
            if (i == 10) begin
                i_LOAD  = 1'b1;
                i_VALUE = 16'h9ABC;
            end else begin
                i_LOAD = 1'b0;
            end
        end
        check_eq("t5_no_fd", 32'(fd_seen), 32'h0);
        i_ENABLE = 1'b1;
        @(negedge i_CLK);
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t5_reen", 7'b0111001, 7'b1111100, 7'b1110111, 7'b1101111);

        // 6: reset mid-frame with a pending load
        repeat (5) @(negedge i_CLK);
        load_now(16'h4321);
        @(negedge i_CLK);
        i_RST      = 1'b1;
        i_BLANK_LZ = 1'b1;
        @(negedge i_CLK);
        check_eq("t6_rst_en", 32'(o_DIGIT_EN), 32'h0);
        check_eq("t6_rst_seg", 32'(o_SEVEN_SEG), 32'h0);
        check_eq("t6_rst_fd", 32'(o_FRAME_DONE), 32'h0);
        i_RST = 1'b0;
        @(negedge i_CLK);
        grab(-1, 16'h0, -1, 16'h0);
        check_frame("t6_cleared", 7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
